// File: rtl/memory_if.sv
// Word-wide memory port: address, write data and write enable in; registered read data out.
interface memory_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  we;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (output addr, output data_in, output we, input  data_out);
  modport slave  (input  addr, input  data_in, input  we, output data_out);
endinterface

// File: rtl/memory.sv
// Single-port synchronous memory with a one-cycle registered read.
// Builds a write-first RAM or a fixed ROM holding the inverted address.
module memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter bit IS_RAM     = 1'b1
) (
  input logic      clk,
  input logic      rst,
  memory_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  // One extra bit keeps the compare correct when MEM_DEPTH == 2**ADDR_WIDTH.
  logic in_range;
  assign in_range = {1'b0, bus.addr} < DEPTH_EXT;

  generate
    if (IS_RAM) begin : g_ram
      logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

      // NOTE: every word is cleared by reset, so the array maps to flops rather than a RAM macro.
      always_ff @(posedge clk) begin
        if (rst) begin
          // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
          bus.data_out <= '0;
          for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
          end
        end else if (!in_range) begin
          bus.data_out <= '0;
        end else if (bus.we) begin
          mem[bus.addr] <= bus.data_in;
          bus.data_out  <= bus.data_in;
        end else begin
          bus.data_out  <= mem[bus.addr];
        end
      end
    end else begin : g_rom
      logic [ADDR_WIDTH-1:0] inv_addr;
      logic                  unused_write_port;

      assign inv_addr          = ~bus.addr;
      assign unused_write_port = ^{bus.we, bus.data_in};

      // Contents are a pure function of the address, so reset only touches the output.
      always_ff @(posedge clk) begin
        if (rst || !in_range) begin
          bus.data_out <= '0;
        end else begin
          bus.data_out <= DATA_WIDTH'(inv_addr);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: RAM, ROM and a shallow RAM instance driven by directed vectors.
module tb_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;

  memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus0 ();
  memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus1 ();
  memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus2 ();

  memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .IS_RAM(1'b1))
    u_ram    (.clk(clk), .rst(rst0), .bus(bus0));
  memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .IS_RAM(1'b0))
    u_rom    (.clk(clk), .rst(rst1), .bus(bus1));
  memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200), .IS_RAM(1'b1))
    u_ram200 (.clk(clk), .rst(rst2), .bus(bus2));

  typedef struct {
    int         dut;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  bit   issue = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Monitor: every edge flagged by the stimulus yields one scoreboard pop.
  always begin
    @(posedge clk);
    if (issue) begin
      #1;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: got empty queue expected an entry");
      end else begin
        exp_t e;
        logic [7:0] act;
        e = sb.pop_front();
        case (e.dut)
          0:       act = bus0.data_out;
          1:       act = bus1.data_out;
          default: act = bus2.data_out;
        endcase
        check(e.name, act, e.exp);
      end
    end
  end

  // One clock cycle of stimulus on instance d; the other instances idle.
  task automatic cyc(input int d, input bit r, input bit w, input logic [7:0] a,
                     input logic [7:0] din, input bit chk, input logic [7:0] exp,
                     input string nm);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    bus0.we = 1'b0; bus1.we = 1'b0; bus2.we = 1'b0;
    case (d)
      0: begin rst0 = r; bus0.we = w; bus0.addr = a; bus0.data_in = din; end
      1: begin rst1 = r; bus1.we = w; bus1.addr = a; bus1.data_in = din; end
      default: begin rst2 = r; bus2.we = w; bus2.addr = a; bus2.data_in = din; end
    endcase
    issue = chk;
    if (chk) sb.push_back('{dut: d, exp: exp, name: nm});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    bus0.addr = '0; bus0.data_in = '0; bus0.we = 1'b0;
    bus1.addr = '0; bus1.data_in = '0; bus1.we = 1'b0;
    bus2.addr = '0; bus2.data_in = '0; bus2.we = 1'b0;

    // RAM: reset, pre-write read, back-to-back writes, reads, write-first, reset mid-operation
    cyc(0, 1, 0, 8'h00, 8'h00, 1, 8'h00, "ram_rst_a");
    cyc(0, 1, 1, 8'h00, 8'hEE, 1, 8'h00, "ram_rst_b");
    cyc(0, 0, 0, 8'hFF, 8'h00, 1, 8'h00, "prewrite_ff");
    cyc(0, 0, 1, 8'h00, 8'h55, 1, 8'h55, "wr_55");
    cyc(0, 0, 1, 8'h01, 8'h66, 1, 8'h66, "wr_66");
    cyc(0, 0, 1, 8'h02, 8'h77, 1, 8'h77, "wr_77");
    cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h55, "rd_00");
    cyc(0, 0, 0, 8'h01, 8'h00, 1, 8'h66, "rd_01");
    cyc(0, 0, 0, 8'h02, 8'h00, 1, 8'h77, "rd_02");
    cyc(0, 0, 1, 8'h10, 8'h3C, 1, 8'h3C, "wf_3c");
    cyc(0, 0, 0, 8'h10, 8'h00, 1, 8'h3C, "rd_10");
    cyc(0, 0, 1, 8'h05, 8'h99, 1, 8'h99, "wr_99");
    cyc(0, 1, 1, 8'h05, 8'h11, 1, 8'h00, "rst_mid");
    cyc(0, 0, 0, 8'h05, 8'h00, 1, 8'h00, "rd_05_after_rst");
    cyc(0, 0, 0, 8'h01, 8'h00, 1, 8'h00, "rd_01_after_rst");

    // ROM: inverted-address contents, write port ignored
    cyc(1, 1, 1, 8'h00, 8'hAA, 1, 8'h00, "rom_rst");
    cyc(1, 0, 1, 8'h00, 8'hAA, 1, 8'hFF, "rom_00_we");
    cyc(1, 0, 1, 8'h01, 8'hAA, 1, 8'hFE, "rom_01_we");
    cyc(1, 0, 1, 8'h02, 8'hAA, 1, 8'hFD, "rom_02_we");
    cyc(1, 0, 0, 8'h00, 8'h00, 1, 8'hFF, "rom_00_again");
    cyc(1, 0, 0, 8'h01, 8'h00, 1, 8'hFE, "rom_01_again");
    cyc(1, 0, 0, 8'h02, 8'h00, 1, 8'hFD, "rom_02_again");
    cyc(1, 0, 0, 8'h80, 8'h00, 1, 8'h7F, "rom_80");
    cyc(1, 0, 0, 8'hFF, 8'h00, 1, 8'h00, "rom_ff");

    // Shallow RAM: out-of-range writes dropped, no aliasing, last legal word usable
    cyc(2, 1, 0, 8'h00, 8'h00, 1, 8'h00, "r200_rst");
    cyc(2, 0, 1, 8'h00, 8'h12, 1, 8'h12, "r200_wr_00");
    cyc(2, 0, 1, 8'hC8, 8'hAB, 1, 8'h00, "oor_write");
    cyc(2, 0, 0, 8'hC8, 8'h00, 1, 8'h00, "oor_read");
    cyc(2, 0, 0, 8'h00, 8'h00, 1, 8'h12, "no_alias_00");
    cyc(2, 0, 1, 8'hC7, 8'h34, 1, 8'h34, "r200_wr_c7");
    cyc(2, 0, 0, 8'hC7, 8'h00, 1, 8'h34, "r200_rd_c7");
    cyc(2, 0, 0, 8'hFF, 8'h00, 1, 8'h00, "oor_read_ff");

    @(negedge clk);
    issue = 1'b0;
    bus0.we = 1'b0; bus1.we = 1'b0; bus2.we = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, giving the address width in bits.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 256, giving the number of words, legal range 1..2^ADDR_WIDTH.
REQ-004 The block SHALL have parameter IS_RAM, default 1, where 1 builds a writable RAM and 0 builds a fixed-content ROM.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, the reset, which is synchronous and active-high.
REQ-007 The block SHALL have port addr, input, ADDR_WIDTH bits, the read/write word address.
REQ-008 The block SHALL have port data_in, input, DATA_WIDTH bits, the write data.
REQ-009 The block SHALL have port we, input, 1 bit, the write enable, active-high.
REQ-010 The block SHALL have port data_out, output, DATA_WIDTH bits, the registered read data.

Function
REQ-011 data_out SHALL be registered, with a read latency of exactly one clk cycle: the value at edge N reflects addr sampled at edge N.
REQ-012 With IS_RAM=1 and we=1 at an edge, the block SHALL store data_in at addr on that edge.
REQ-013 With IS_RAM=1 and we=1, the read SHALL be write-first: data_out on that edge equals data_in.
REQ-014 With IS_RAM=1 and we=0, data_out SHALL load the stored word at addr.
REQ-015 With IS_RAM=0, the block SHALL ignore we and data_in entirely, and contents SHALL never change.
REQ-016 ROM contents SHALL be the bitwise inverse of the address, zero-extended or truncated to DATA_WIDTH (at width 8: addr 0x00 -> 0xFF, 0x01 -> 0xFE, 0x02 -> 0xFD).
REQ-017 If addr >= MEM_DEPTH, a write SHALL be ignored with no aliasing, and data_out SHALL load 0.
REQ-018 Back-to-back writes on consecutive edges to different addresses SHALL all be stored, with no dead cycles.
REQ-019 A write followed on the next edge by a read of the same address SHALL return the newly written data.
REQ-020 Unwritten RAM words after reset SHALL read 0.
REQ-021 The block SHALL be a single clock domain with no combinational path from any input to data_out.

Reset
REQ-022 When rst=1 at an edge, data_out SHALL become 0 on that edge.
REQ-023 When rst=1 at an edge with IS_RAM=1, all RAM words SHALL become 0 on that edge.
REQ-024 rst SHALL have priority over we: a write presented during reset is discarded.
REQ-025 ROM contents SHALL be unaffected by rst.
REQ-026 The first valid read SHALL be on the first edge with rst=0, giving data at the next edge.

Verification
REQ-027 Reset and write: assert rst for 2 cycles, then with IS_RAM=1 write 0x55@0x00, 0x66@0x01, 0x77@0x02 on consecutive edges, then read each -> data_out = 0x55, 0x66, 0x77, each one cycle after its address.
REQ-028 ROM read: with IS_RAM=0, read 0x00, 0x01, 0x02 while we=1 and data_in=0xAA -> data_out = 0xFF, 0xFE, 0xFD, and contents are unchanged.
REQ-029 Write-first: with IS_RAM=1, write 0x3C@0x10 -> data_out = 0x3C on the write edge; a subsequent read of 0x10 also gives 0x3C.
REQ-030 Reset mid-operation: write 0x99@0x05, then assert rst with we=1, data_in=0x11, addr=0x05 -> data_out = 0x00; after reset, reading 0x05 gives 0x00.
REQ-031 Out of range: with MEM_DEPTH=200, write 0xAB@0xC8 (200), then read 0xC8 -> 0x00, and address 0x00 is not modified.
REQ-032 Pre-write read: after reset, read 0xFF before any write -> 0x00.
